// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the L2 request arbiter: request/response encodings and payload structs.
package l2_request_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 512;
  localparam int MASK_W  = 64;
  localparam int IDX_W   = 2;
  localparam int COUNT_W = 4;

  typedef logic [ADDR_W-1:0] scalar_t;
  typedef logic [DATA_W-1:0] cache_line_data_t;
  typedef logic [MASK_W-1:0] cache_line_mask_t;
  typedef logic [IDX_W-1:0]  l1_miss_entry_idx_t;
  typedef logic [IDX_W-1:0]  thread_idx_t;

  typedef enum logic [1:0] {
    L2_REQ_LOAD       = 2'd0,
    L2_REQ_STORE      = 2'd1,
    L2_REQ_LOAD_SYNC  = 2'd2,
    L2_REQ_STORE_SYNC = 2'd3
  } l2_req_type_t;

  typedef struct packed {
    l2_req_type_t     req_type;
    scalar_t          addr;
    cache_line_data_t data;
    cache_line_mask_t mask;
    logic [IDX_W-1:0] id;
  } l2_request_t;

  typedef struct packed {
    logic             valid;
    l2_req_type_t     resp_type;
    logic [IDX_W-1:0] id;
    logic             status;
  } l2_response_t;

  function automatic logic is_store_type(input l2_req_type_t t);
    return (t == L2_REQ_STORE) || (t == L2_REQ_STORE_SYNC);
  endfunction

endpackage

// File: rtl/l2_request_arbiter_arbiter.sv
// Generic round-robin arbiter: the entry after the last winner has priority; entry 0 after reset.
module arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_ENTRIES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENTRIES-1:0] request,
  input  logic                   update_lru,
  output logic [NUM_ENTRIES-1:0] grant_oh
);

  logic [NUM_ENTRIES-1:0] priority_oh;
  logic [NUM_ENTRIES-1:0] at_or_above;
  logic [NUM_ENTRIES-1:0] masked_request;
  logic [NUM_ENTRIES-1:0] candidates;

  // Search from the priority entry upward, wrapping to the lowest requester if none is above it.
  always_comb begin
    at_or_above    = ~(priority_oh - NUM_ENTRIES'(1));
    masked_request = request & at_or_above;
    candidates     = (masked_request != '0) ? masked_request : request;
    grant_oh       = candidates & (~candidates + NUM_ENTRIES'(1));
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      priority_oh <= NUM_ENTRIES'(1);
    end else if (update_lru) begin
      priority_oh <= {grant_oh[NUM_ENTRIES-2:0], grant_oh[NUM_ENTRIES-1]};
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the L2 request port between the load miss queue and store queue, with a credit limit,
// and routes L2 responses back to the requesting queue.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         load_ready,
  input  logic [31:0]  load_addr,
  input  logic [1:0]   load_idx,
  input  logic         load_synchronized,
  output logic         load_ack,

  input  logic         store_ready,
  input  logic [31:0]  store_addr,
  input  logic [511:0] store_data,
  input  logic [63:0]  store_mask,
  input  logic [1:0]   store_idx,
  input  logic         store_synchronized,
  output logic         store_ack,

  output logic         l2_request_valid,
  input  logic         l2_request_ready,
  output logic [1:0]   l2_request_type,
  output logic [31:0]  l2_request_addr,
  output logic [511:0] l2_request_data,
  output logic [63:0]  l2_request_mask,
  output logic [1:0]   l2_request_id,

  input  logic         l2_response_valid,
  input  logic [1:0]   l2_response_type,
  input  logic [1:0]   l2_response_id,
  input  logic         l2_response_status,

  output logic         load_response_valid,
  output logic [1:0]   load_response_idx,
  output logic         store_response_valid,
  output logic [1:0]   store_response_idx,
  output logic         store_response_status,

  output logic [3:0]   outstanding_count
);

  l2_request_t        request_q;
  logic               request_valid_q;
  logic [COUNT_W-1:0] count_q;

  l2_request_t        load_request;
  l2_request_t        store_request;
  l2_response_t       response;

  logic               request_free;
  logic               can_grant;
  logic               handshake;
  logic               response_retire;
  logic [1:0]         arb_request;
  logic [1:0]         grant_oh;

  assign request_free = !request_valid_q || l2_request_ready;
  // Credit check sees only the registered count; a response arriving this cycle frees a slot next cycle.
  assign can_grant    = !reset && request_free && (count_q < COUNT_W'(MAX_OUTSTANDING));
  assign arb_request  = {store_ready, load_ready} & {2{can_grant}};

  arbiter #(
    .NUM_ENTRIES (2)
  ) u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .request    (arb_request),
    .update_lru (|grant_oh),
    .grant_oh   (grant_oh)
  );

  assign load_ack  = grant_oh[0];
  assign store_ack = grant_oh[1];

  // NOTE: every field gets a default before the overrides so no path leaves a latch behind.
  always_comb begin
    load_request          = '0;
    load_request.req_type = load_synchronized ? L2_REQ_LOAD_SYNC : L2_REQ_LOAD;
    load_request.addr     = load_addr;
    load_request.id       = load_idx;

    store_request          = '0;
    store_request.req_type = store_synchronized ? L2_REQ_STORE_SYNC : L2_REQ_STORE;
    store_request.addr     = store_addr;
    store_request.data     = store_data;
    store_request.mask     = store_mask;
    store_request.id       = store_idx;
  end

  assign response = '{
    valid:     l2_response_valid,
    resp_type: l2_req_type_t'(l2_response_type),
    id:        l2_response_id,
    status:    l2_response_status
  };

  // NOTE: the wide payload is reset as well because its reset value is visible on the output ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      request_valid_q <= 1'b0;
      request_q       <= '0;
    end else if (load_ack) begin
      request_valid_q <= 1'b1;
      request_q       <= load_request;
    end else if (store_ack) begin
      request_valid_q <= 1'b1;
      request_q       <= store_request;
    end else if (l2_request_ready) begin
      request_valid_q <= 1'b0;
    end
  end

  assign handshake       = request_valid_q && l2_request_ready;
  assign response_retire = response.valid && (count_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      unique case ({handshake, response_retire})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_response_valid   <= 1'b0;
      load_response_idx     <= '0;
      store_response_valid  <= 1'b0;
      store_response_idx    <= '0;
      store_response_status <= 1'b0;
    end else begin
      load_response_valid  <= response.valid && !is_store_type(response.resp_type);
      store_response_valid <= response.valid && is_store_type(response.resp_type);
      if (response.valid) begin
        if (is_store_type(response.resp_type)) begin
          store_response_idx    <= response.id;
          store_response_status <= response.status;
        end else begin
          load_response_idx <= response.id;
        end
      end
    end
  end

  // A response with nothing in flight means the environment lost track of its requests.
  response_without_credit: assert property (
    @(posedge clk) disable iff (reset) !(l2_response_valid && count_q == '0)
  );

  assign l2_request_valid  = request_valid_q;
  assign l2_request_type   = request_q.req_type;
  assign l2_request_addr   = request_q.addr;
  assign l2_request_data   = request_q.data;
  assign l2_request_mask   = request_q.mask;
  assign l2_request_id     = request_q.id;
  assign outstanding_count = count_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_l2_request_arbiter;

  localparam int MAX = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_ready, load_synchronized, load_ack;
  logic [31:0]  load_addr;
  logic [1:0]   load_idx;
  logic         store_ready, store_synchronized, store_ack;
  logic [31:0]  store_addr;
  logic [511:0] store_data;
  logic [63:0]  store_mask;
  logic [1:0]   store_idx;
  logic         l2_request_valid, l2_request_ready;
  logic [1:0]   l2_request_type, l2_request_id;
  logic [31:0]  l2_request_addr;
  logic [511:0] l2_request_data;
  logic [63:0]  l2_request_mask;
  logic         l2_response_valid, l2_response_status;
  logic [1:0]   l2_response_type, l2_response_id;
  logic         load_response_valid, store_response_valid, store_response_status;
  logic [1:0]   load_response_idx, store_response_idx;
  logic [3:0]   outstanding_count;

  int n_checks = 0;
  int n_errors = 0;

  l2_request_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset),
    .load_ready(load_ready), .load_addr(load_addr), .load_idx(load_idx),
    .load_synchronized(load_synchronized), .load_ack(load_ack),
    .store_ready(store_ready), .store_addr(store_addr), .store_data(store_data),
    .store_mask(store_mask), .store_idx(store_idx),
    .store_synchronized(store_synchronized), .store_ack(store_ack),
    .l2_request_valid(l2_request_valid), .l2_request_ready(l2_request_ready),
    .l2_request_type(l2_request_type), .l2_request_addr(l2_request_addr),
    .l2_request_data(l2_request_data), .l2_request_mask(l2_request_mask),
    .l2_request_id(l2_request_id),
    .l2_response_valid(l2_response_valid), .l2_response_type(l2_response_type),
    .l2_response_id(l2_response_id), .l2_response_status(l2_response_status),
    .load_response_valid(load_response_valid), .load_response_idx(load_response_idx),
    .store_response_valid(store_response_valid), .store_response_idx(store_response_idx),
    .store_response_status(store_response_status),
    .outstanding_count(outstanding_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_ready = 0; load_addr = 0; load_idx = 0; load_synchronized = 0;
    store_ready = 0; store_addr = 0; store_data = 0; store_mask = 0; store_idx = 0;
    store_synchronized = 0; l2_request_ready = 0;
    l2_response_valid = 0; l2_response_type = 0; l2_response_id = 0; l2_response_status = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Drives one load through grant and handshake, leaving it counted as in flight.
  task automatic issue_load(input logic [1:0] idx);
    load_ready = 1; load_idx = idx; load_addr = 32'h5000 + 32'(idx) * 32'h40;
    l2_request_ready = 1;
    tick();
    load_ready = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; load_ready = 1; store_ready = 1; l2_request_ready = 1;
    tick();
    tick();
    n_checks++; if ({load_ack, store_ack} !== 2'b00) begin n_errors++; $display("FAIL reset_acks: got %b expected 00", {load_ack, store_ack}); end
    n_checks++; if (l2_request_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", l2_request_valid); end
    n_checks++; if ({l2_request_type, l2_request_addr, l2_request_mask, l2_request_id} !== '0) begin n_errors++; $display("FAIL reset_fields: got type=%h addr=%h mask=%h id=%h expected all 0", l2_request_type, l2_request_addr, l2_request_mask, l2_request_id); end
    n_checks++; if (l2_request_data !== '0) begin n_errors++; $display("FAIL reset_data: got nonzero %h expected 0", l2_request_data[63:0]); end
    n_checks++; if ({load_response_valid, load_response_idx, store_response_valid, store_response_idx, store_response_status} !== 7'd0) begin n_errors++; $display("FAIL reset_responses: got %b expected 0", {load_response_valid, load_response_idx, store_response_valid, store_response_idx, store_response_status}); end
    n_checks++; if (outstanding_count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", outstanding_count); end
    do_reset();
  endtask

  task automatic test_single_load();
    do_reset();
    load_ready = 1; load_addr = 32'h1000; load_idx = 2; l2_request_ready = 1;
    #1;
    n_checks++; if ({load_ack, store_ack} !== 2'b10) begin n_errors++; $display("FAIL single_ack: got %b expected 10", {load_ack, store_ack}); end
    tick();
    load_ready = 0;
    #1;
    n_checks++; if ({l2_request_valid, l2_request_type, l2_request_addr, l2_request_id} !== {1'b1, 2'd0, 32'h1000, 2'd2}) begin n_errors++; $display("FAIL single_request: got v=%b t=%0d a=%h id=%0d expected v=1 t=0 a=1000 id=2", l2_request_valid, l2_request_type, l2_request_addr, l2_request_id); end
    n_checks++; if ({l2_request_data, l2_request_mask} !== '0) begin n_errors++; $display("FAIL single_load_payload: got mask=%h expected data/mask 0", l2_request_mask); end
    tick();
    n_checks++; if ({l2_request_valid, outstanding_count} !== {1'b0, 4'd1}) begin n_errors++; $display("FAIL single_count: got v=%b count=%0d expected v=0 count=1", l2_request_valid, outstanding_count); end
    l2_response_valid = 1; l2_response_type = 2'd0; l2_response_id = 2;
    tick();
    l2_response_valid = 0;
    #1;
    n_checks++; if ({load_response_valid, load_response_idx, store_response_valid, outstanding_count} !== {1'b1, 2'd2, 1'b0, 4'd0}) begin n_errors++; $display("FAIL single_response: got lv=%b li=%0d sv=%b count=%0d expected lv=1 li=2 sv=0 count=0", load_response_valid, load_response_idx, store_response_valid, outstanding_count); end
    tick();
    n_checks++; if (load_response_valid !== 1'b0) begin n_errors++; $display("FAIL single_response_pulse: got %b expected 0", load_response_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_type = 0;
    logic [31:0]  exp_addr = 0;
    logic [511:0] exp_data = 0;
    logic [63:0]  exp_mask = 0;
    logic [1:0]   exp_id = 0;
    do_reset();
    l2_request_ready = 1; load_ready = 1; store_ready = 1;
    for (int i = 0; i < 5; i++) begin
      load_addr = 32'h2000 + 32'(i) * 32'h40; load_idx = 2'(i); load_synchronized = (i == 2);
      store_addr = 32'h3000 + 32'(i) * 32'h40; store_idx = 2'(3 - i); store_synchronized = (i == 3);
      store_data = {16{$urandom}}; store_mask = {$urandom, $urandom};
      if (i == 4) begin load_ready = 0; store_ready = 0; end
      #1;
      if (i > 0) begin
        n_checks++; if ({l2_request_valid, l2_request_type, l2_request_addr, l2_request_id, l2_request_mask} !== {1'b1, exp_type, exp_addr, exp_id, exp_mask}) begin n_errors++; $display("FAIL rr_request_%0d: got v=%b t=%0d a=%h id=%0d m=%h expected v=1 t=%0d a=%h id=%0d m=%h", i, l2_request_valid, l2_request_type, l2_request_addr, l2_request_id, l2_request_mask, exp_type, exp_addr, exp_id, exp_mask); end
        n_checks++; if (l2_request_data !== exp_data) begin n_errors++; $display("FAIL rr_data_%0d: got %h expected %h (low 64 bits)", i, l2_request_data[63:0], exp_data[63:0]); end
      end
      if (i < 4) begin
        n_checks++; if ({load_ack, store_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL rr_ack_%0d: got %b expected %b", i, {load_ack, store_ack}, (i % 2 == 0) ? 2'b10 : 2'b01); end
        if (i % 2 == 0) begin
          exp_type = load_synchronized ? 2'd2 : 2'd0; exp_addr = load_addr; exp_data = '0; exp_mask = '0; exp_id = load_idx;
        end else begin
          exp_type = store_synchronized ? 2'd3 : 2'd1; exp_addr = store_addr; exp_data = store_data; exp_mask = store_mask; exp_id = store_idx;
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [511:0] d1, d2;
    logic [63:0]  m1;
    do_reset();
    d1 = {16{$urandom}}; d2 = {16{$urandom}}; m1 = {$urandom, $urandom};
    store_ready = 1; store_addr = 32'h4000; store_data = d1; store_mask = m1; store_idx = 1;
    l2_request_ready = 0;
    #1;
    n_checks++; if ({load_ack, store_ack} !== 2'b01) begin n_errors++; $display("FAIL stall_first_ack: got %b expected 01", {load_ack, store_ack}); end
    tick();
    store_addr = 32'h4040; store_data = d2; store_mask = ~m1; store_idx = 2;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (store_ack !== 1'b0) begin n_errors++; $display("FAIL stall_no_ack_%0d: got %b expected 0", c, store_ack); end
      n_checks++; if ({l2_request_valid, l2_request_type, l2_request_addr, l2_request_id, l2_request_mask, l2_request_data} !== {1'b1, 2'd1, 32'h4000, 2'd1, m1, d1}) begin n_errors++; $display("FAIL stall_hold_%0d: got v=%b t=%0d a=%h id=%0d expected v=1 t=1 a=4000 id=1 with first payload", c, l2_request_valid, l2_request_type, l2_request_addr, l2_request_id); end
      tick();
    end
    l2_request_ready = 1;
    #1;
    n_checks++; if ({store_ack, l2_request_addr} !== {1'b1, 32'h4000}) begin n_errors++; $display("FAIL stall_release: got ack=%b a=%h expected ack=1 a=4000", store_ack, l2_request_addr); end
    tick();
    store_ready = 0;
    #1;
    n_checks++; if ({l2_request_valid, l2_request_addr, l2_request_id, l2_request_data, outstanding_count} !== {1'b1, 32'h4040, 2'd2, d2, 4'd1}) begin n_errors++; $display("FAIL stall_next: got v=%b a=%h id=%0d count=%0d expected v=1 a=4040 id=2 count=1", l2_request_valid, l2_request_addr, l2_request_id, outstanding_count); end
  endtask

  task automatic test_credit_limit();
    do_reset();
    issue_load(0);
    issue_load(1);
    issue_load(2);
    load_ready = 1; load_idx = 3; load_addr = 32'h6000;
    l2_response_valid = 1; l2_response_type = 2'd0; l2_response_id = 1;
    #1;
    n_checks++; if ({outstanding_count, load_ack} !== {4'd3, 1'b0}) begin n_errors++; $display("FAIL credit_block: got count=%0d ack=%b expected count=3 ack=0", outstanding_count, load_ack); end
    tick();
    l2_response_valid = 0;
    #1;
    n_checks++; if ({load_response_valid, load_response_idx} !== {1'b1, 2'd1}) begin n_errors++; $display("FAIL credit_response: got v=%b idx=%0d expected v=1 idx=1", load_response_valid, load_response_idx); end
    n_checks++; if ({outstanding_count, load_ack} !== {4'd2, 1'b1}) begin n_errors++; $display("FAIL credit_release: got count=%0d ack=%b expected count=2 ack=1", outstanding_count, load_ack); end
    tick();
    load_ready = 0;
    #1;
    n_checks++; if ({l2_request_valid, l2_request_id, load_response_valid} !== {1'b1, 2'd3, 1'b0}) begin n_errors++; $display("FAIL credit_third: got v=%b id=%0d lrv=%b expected v=1 id=3 lrv=0", l2_request_valid, l2_request_id, load_response_valid); end
  endtask

  task automatic test_store_sync_response();
    do_reset();
    store_ready = 1; store_idx = 3; store_synchronized = 1; l2_request_ready = 1;
    tick();
    store_ready = 0;
    tick();
    l2_response_valid = 1; l2_response_type = 2'd3; l2_response_id = 3; l2_response_status = 1;
    tick();
    l2_response_valid = 0; l2_response_status = 0;
    #1;
    n_checks++; if ({store_response_valid, store_response_idx, store_response_status, load_response_valid} !== {1'b1, 2'd3, 1'b1, 1'b0}) begin n_errors++; $display("FAIL sync_response: got sv=%b si=%0d ss=%b lv=%b expected sv=1 si=3 ss=1 lv=0", store_response_valid, store_response_idx, store_response_status, load_response_valid); end
    n_checks++; if (outstanding_count !== 4'd0) begin n_errors++; $display("FAIL sync_count: got %0d expected 0", outstanding_count); end
    tick();
    n_checks++; if (store_response_valid !== 1'b0) begin n_errors++; $display("FAIL sync_pulse: got %b expected 0", store_response_valid); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_load(0);
    issue_load(1);
    store_ready = 1; store_addr = 32'h7000; l2_request_ready = 0;
    tick();
    store_ready = 0; load_ready = 1; load_idx = 2; l2_request_ready = 1;
    tick();
    load_ready = 0; l2_request_ready = 0;
    #1;
    n_checks++; if ({l2_request_valid, outstanding_count} !== {1'b1, 4'd3}) begin n_errors++; $display("FAIL midop_setup: got v=%b count=%0d expected v=1 count=3", l2_request_valid, outstanding_count); end
    reset = 1; load_ready = 1; store_ready = 1;
    tick();
    reset = 0;
    #1;
    n_checks++; if ({l2_request_valid, outstanding_count} !== {1'b0, 4'd0}) begin n_errors++; $display("FAIL midop_cleared: got v=%b count=%0d expected v=0 count=0", l2_request_valid, outstanding_count); end
    n_checks++; if ({load_ack, store_ack} !== 2'b10) begin n_errors++; $display("FAIL midop_priority: got %b expected 10", {load_ack, store_ack}); end
    tick();
    clear_inputs();
  endtask

  // Reference model tracks transactions: one pending request slot, an in-flight counter,
  // whose turn it is, and the last routed response.
  task automatic test_random();
    logic         m_valid = 0;
    logic [1:0]   m_type = 0, m_id = 0;
    logic [31:0]  m_addr = 0;
    logic [511:0] m_data = 0;
    logic [63:0]  m_mask = 0;
    int           m_count = 0;
    int           m_turn = 0;
    logic         m_lrv = 0, m_srv = 0, m_srs = 0;
    logic [1:0]   m_lri = 0, m_sri = 0;
    logic         g_load, g_store, room;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      load_ready = 1'($urandom_range(0, 1)); store_ready = 1'($urandom_range(0, 1));
      load_addr = $urandom; load_idx = 2'($urandom); load_synchronized = 1'($urandom);
      store_addr = $urandom; store_idx = 2'($urandom); store_synchronized = 1'($urandom);
      store_data = {16{$urandom}}; store_mask = {$urandom, $urandom};
      l2_request_ready = ($urandom_range(0, 3) != 0);
      l2_response_valid = (m_count > 0) && ($urandom_range(0, 1) == 1);
      l2_response_type = 2'($urandom); l2_response_id = 2'($urandom); l2_response_status = 1'($urandom);
      #1;
      room = (!m_valid || l2_request_ready) && (m_count < MAX);
      g_load = room && load_ready && (!store_ready || m_turn == 0);
      g_store = room && store_ready && (!load_ready || m_turn == 1);
      n_checks++; if ({load_ack, store_ack} !== {g_load, g_store}) begin n_errors++; $display("FAIL rand_ack@%0d: got %b expected %b", cyc, {load_ack, store_ack}, {g_load, g_store}); end
      n_checks++; if (l2_request_valid !== m_valid) begin n_errors++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, l2_request_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if ({l2_request_type, l2_request_addr, l2_request_id, l2_request_mask, l2_request_data} !== {m_type, m_addr, m_id, m_mask, m_data}) begin n_errors++; $display("FAIL rand_request@%0d: got t=%0d a=%h id=%0d expected t=%0d a=%h id=%0d", cyc, l2_request_type, l2_request_addr, l2_request_id, m_type, m_addr, m_id); end
      end
      n_checks++; if (outstanding_count !== 4'(m_count)) begin n_errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", cyc, outstanding_count, m_count); end
      n_checks++; if ({load_response_valid, store_response_valid} !== {m_lrv, m_srv}) begin n_errors++; $display("FAIL rand_resp_valid@%0d: got %b expected %b", cyc, {load_response_valid, store_response_valid}, {m_lrv, m_srv}); end
      if (m_lrv) begin
        n_checks++; if (load_response_idx !== m_lri) begin n_errors++; $display("FAIL rand_load_idx@%0d: got %0d expected %0d", cyc, load_response_idx, m_lri); end
      end
      if (m_srv) begin
        n_checks++; if ({store_response_idx, store_response_status} !== {m_sri, m_srs}) begin n_errors++; $display("FAIL rand_store_resp@%0d: got idx=%0d st=%b expected idx=%0d st=%b", cyc, store_response_idx, store_response_status, m_sri, m_srs); end
      end
      tick();
      m_count = m_count + ((m_valid && l2_request_ready) ? 1 : 0) - ((l2_response_valid && m_count > 0) ? 1 : 0);
      if (g_load) begin
        m_valid = 1; m_type = load_synchronized ? 2'd2 : 2'd0; m_addr = load_addr;
        m_data = '0; m_mask = '0; m_id = load_idx; m_turn = 1;
      end else if (g_store) begin
        m_valid = 1; m_type = store_synchronized ? 2'd3 : 2'd1; m_addr = store_addr;
        m_data = store_data; m_mask = store_mask; m_id = store_idx; m_turn = 0;
      end else if (l2_request_ready) begin
        m_valid = 0;
      end
      m_lrv = l2_response_valid && (l2_response_type == 2'd0 || l2_response_type == 2'd2);
      m_srv = l2_response_valid && (l2_response_type == 2'd1 || l2_response_type == 2'd3);
      if (m_lrv) m_lri = l2_response_id;
      if (m_srv) begin m_sri = l2_response_id; m_srs = l2_response_status; end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_load();
    test_round_robin();
    test_stall();
    test_credit_limit();
    test_store_sync_response();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
